image_stream_rx: RTL
====================

Name: image_stream_rx

Overview:
- Receiver end of the byte-serial image stream the board-level driver sends into the MNIST core: one 8-bit byte per cycle, two bytes per 16-pixel row, 32 bytes per 16x16 binary frame.
- Detects frame start, deserialises the bytes into a 256-bit frame register and hands completed frames to the classifier through a valid/ready handshake.
- Flags framing errors and frames dropped because the previous frame was not taken.

Parameters:
- BYTES_PER_FRAME, 32, bytes per frame; must be even; frame width = 8*BYTES_PER_FRAME.
- IDX_W, 5, width of byte_index; must satisfy 2^IDX_W >= BYTES_PER_FRAME.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous reset, active-high.
- in_byte  in  8  stream byte.
- in_valid  in  1  in_byte is valid this cycle.
- in_sof  in  1  start-of-frame; meaningful only when in_valid=1; marks byte 0.
- frame_out  out  256  completed frame; row r = frame_out[16r +: 16] = {byte 2r, byte 2r+1}.
- frame_valid  out  1  frame_out holds an untaken frame (level).
- frame_ready  in  1  consumer takes the frame when frame_valid=1.
- busy  out  1  state is RECV.
- byte_index  out  IDX_W  index of the next expected byte; 0 when IDLE.
- sof_err  out  1  one-cycle pulse: in_sof arrived mid-frame.
- stray_err  out  1  one-cycle pulse: valid byte without in_sof while IDLE.
- overflow  out  1  one-cycle pulse: a completed frame was dropped.

Behaviour:
- Reset: state IDLE, byte_index=0, frame_out=0, frame_valid=0, busy=0, all error pulses 0. Reset mid-frame discards the partial frame and clears any pending frame.
- IDLE, in_valid & in_sof:
  - Byte goes to slot 0 of the assembly register.
  - byte_index becomes 1; state goes to RECV.
- IDLE, in_valid & !in_sof: byte discarded, stray_err pulses next cycle, state stays IDLE.
- RECV, in_valid & !in_sof:
  - Byte k = byte_index goes to assembly slot k.
  - Even k goes to bits [8k+15 -: 8] (row high half); odd k goes to bits [8k-8 +: 8] (row low half). Net result: row r = {byte 2r, byte 2r+1}, MSB = leftmost pixel.
  - byte_index increments.
- RECV, in_valid & in_sof: the partial frame is abandoned and this byte restarts at slot 0. byte_index=1, sof_err pulses next cycle, state stays RECV.
- RECV, !in_valid: hold; there is no timeout; gaps of any length are allowed.
- Completion: accepting byte BYTES_PER_FRAME-1 ends the frame. The next cycle, state=IDLE and byte_index=0, and the assembly register is offered to the output:
  - Output free (frame_valid=0), or frame_ready=1 in the completion cycle: frame_out loads the assembled frame and frame_valid=1. Latency is 1 cycle from the last byte to frame_valid.
  - Output occupied and frame_ready=0: the new frame is dropped, frame_out and frame_valid are unchanged, and overflow pulses.
- Handshake: frame_valid & frame_ready clears frame_valid next cycle, unless a frame completes in the same cycle, in which case frame_valid stays 1 and frame_out takes the new frame. frame_out holds its value while frame_valid=0.
- A byte carrying in_sof in the cycle immediately after completion starts a new frame normally; back-to-back frames run with zero idle cycles.
- The assembly register is never visible on frame_out until it is complete.
- Error pulses are each at most 1 cycle wide and independent; several may be high together.

Test Plan:
- Reset, then 32 back-to-back bytes 0x00,0x01,…,0x1F with in_sof on the first and frame_ready=1 -> frame_valid=1 exactly one cycle after byte 31; frame_out[15:0]=0x0001; frame_out[255:240]=0x1E1F.
- Frame of the digit-0 pattern (bytes 4,5 = 0x03,0xE0), frame_ready=0 -> frame_out[47:32]=0x03E0 and frame_valid stays 1. A second full frame with frame_ready=0 -> overflow pulses once and frame_out is unchanged. Raise frame_ready -> frame_valid=0 next cycle.
- in_valid=1 and in_sof=0 from IDLE for 3 bytes -> 3 stray_err pulses, busy=0, byte_index=0.
- in_sof at byte_index=10, then 32 bytes -> sof_err pulses once; the delivered frame contains only the bytes from the second in_sof.
- in_valid toggled 1/0 per cycle over a frame -> frame identical to the gap-free case; completion 1 cycle after the 32nd valid byte.
- reset asserted at byte_index=20 -> next cycle busy=0, byte_index=0, frame_valid=0; a following full frame is received correctly.

Source files
------------

// File: rtl/image_stream_rx.sv
// Purpose: deserialise the byte-serial binary image stream into 256-bit frames for the classifier.
// Latency: frame_valid rises 1 cycle after the last byte of a frame is accepted.
// Backpressure: none upstream; a completed frame is dropped (overflow pulse) if the output slot is still held.
module image_stream_rx #(
  parameter int BYTES_PER_FRAME = 32,
  parameter int IDX_W           = 5
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [7:0]                   in_byte,
  input  logic                         in_valid,
  input  logic                         in_sof,
  output logic [8*BYTES_PER_FRAME-1:0] frame_out,
  output logic                         frame_valid,
  input  logic                         frame_ready,
  output logic                         busy,
  output logic [IDX_W-1:0]             byte_index,
  output logic                         sof_err,
  output logic                         stray_err,
  output logic                         overflow
);

  localparam int                FW       = 8 * BYTES_PER_FRAME;
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(BYTES_PER_FRAME - 1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RECV = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [FW-1:0]    asm_q, asm_d;
  logic [FW-1:0]    frame_q, frame_d;
  logic             fvld_q, fvld_d;
  logic             sof_err_q, sof_err_d;
  logic             stray_err_q, stray_err_d;
  logic             ovf_q, ovf_d;

  logic             wr_en;
  logic [IDX_W-1:0] wr_idx;
  logic             done;

  // Register stage: everything, including the pending output frame, clears on reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      asm_q       <= '0;
      frame_q     <= '0;
      fvld_q      <= 1'b0;
      sof_err_q   <= 1'b0;
      stray_err_q <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      asm_q       <= asm_d;
      frame_q     <= frame_d;
      fvld_q      <= fvld_d;
      sof_err_q   <= sof_err_d;
      stray_err_q <= stray_err_d;
      ovf_q       <= ovf_d;
    end
  end

  // Framing FSM, byte placement and output-slot handoff.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    asm_d       = asm_q;
    frame_d     = frame_q;
    fvld_d      = fvld_q;
    sof_err_d   = 1'b0;
    stray_err_d = 1'b0;
    ovf_d       = 1'b0;
    wr_en       = 1'b0;
    wr_idx      = '0;
    done        = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          if (in_sof) begin
            wr_en   = 1'b1;
            asm_d   = '0;
            idx_d   = IDX_W'(1);
            state_d = S_RECV;
          end else begin
            stray_err_d = 1'b1;
          end
        end
      end
      S_RECV: begin
        if (in_valid) begin
          wr_en = 1'b1;
          if (in_sof) begin
            // Restart: abandon the partial frame, this byte becomes byte 0.
            asm_d     = '0;
            idx_d     = IDX_W'(1);
            sof_err_d = 1'b1;
          end else begin
            wr_idx = idx_q;
            if (idx_q == LAST_IDX) begin
              done    = 1'b1;
              idx_d   = '0;
              state_d = S_IDLE;
            end else begin
              idx_d = idx_q + IDX_W'(1);
            end
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        idx_d   = '0;
      end
    endcase

    // Byte k lands in slot k^1 so each row reads {byte 2r, byte 2r+1}, leftmost pixel at the MSB.
    for (int s = 0; s < BYTES_PER_FRAME; s++) begin
      if (wr_en && (IDX_W'(s) == (wr_idx ^ IDX_W'(1)))) begin
        asm_d[8*s +: 8] = in_byte;
      end
    end

    if (fvld_q && frame_ready) begin
      fvld_d = 1'b0;
    end

    // A finished frame takes the slot if it is free or being emptied this cycle, else it is lost.
    if (done) begin
      if (!fvld_q || frame_ready) begin
        frame_d = asm_d;
        fvld_d  = 1'b1;
      end else begin
        ovf_d = 1'b1;
      end
    end
  end

  assign frame_out   = frame_q;
  assign frame_valid = fvld_q;
  assign busy        = (state_q == S_RECV);
  assign byte_index  = idx_q;
  assign sof_err     = sof_err_q;
  assign stray_err   = stray_err_q;
  assign overflow    = ovf_q;

endmodule
